// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding instruction-bus request
// and holds the fetched word until decode takes it. Optional feature: FETCH_MISALIGN_EN.
module fetch_unit #(
    parameter int unsigned      XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = 64'h8000_0000,
    parameter logic [31:0]      NOP_INSN = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            iresp_data_ok,
    input  logic [31:0]     iresp_data,
    input  logic            stall_f,
    input  logic            flush_f,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_pc,
    input  logic            trap_redirect,
    input  logic [XLEN-1:0] trap_pc,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_insn,
    output logic            fetch_busy,
    output logic            out_misalign
);

    localparam logic [0:0] ST_REQ  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            drop_q, drop_d;
    logic            reset_q;
    logic            valid_d;
    logic [XLEN-1:0] out_pc_d;
    logic [31:0]     insn_d;
    logic            misalign_q, misalign_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            pc_misaligned;
    logic            req_live;

    assign redirect = trap_redirect | jump;
    assign target   = trap_redirect ? trap_pc : jump_pc;

`ifdef FETCH_MISALIGN_EN
    assign pc_misaligned = (pc_q[1:0] != 2'b00);
    assign ireq_addr     = pc_q;
`else
    assign pc_misaligned = 1'b0;
    assign ireq_addr     = {pc_q[XLEN-1:2], 2'b00};
`endif

    assign ireq_valid   = (state_q == ST_REQ) & ~pc_misaligned;
    assign fetch_busy   = ireq_valid;
    assign out_misalign = misalign_q;

    // A request is genuinely on the bus only if it was issued outside reset and not yet answered.
    assign req_live = ireq_valid & ~iresp_data_ok & ~reset_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        drop_d     = drop_q;
        valid_d    = out_valid;
        out_pc_d   = out_pc;
        insn_d     = out_insn;
        misalign_d = misalign_q;

        case (state_q)
            ST_REQ: begin
                if (pc_misaligned) begin
                    if (redirect) begin
                        pc_d = target;
                    end else begin
                        state_d    = ST_HOLD;
                        valid_d    = 1'b1;
                        insn_d     = NOP_INSN;
                        out_pc_d   = pc_q;
                        misalign_d = 1'b1;
                    end
                end else if (!iresp_data_ok) begin
                    if (redirect) begin
                        drop_d    = 1'b1;
                        pend_pc_d = target;
                    end
                end else if (drop_q || redirect) begin
                    pc_d   = redirect ? target : pend_pc_q;
                    drop_d = 1'b0;
                end else if (!flush_f) begin
                    state_d    = ST_HOLD;
                    valid_d    = 1'b1;
                    insn_d     = iresp_data;
                    out_pc_d   = pc_q;
                    misalign_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (redirect || flush_f || !stall_f) begin
                    state_d    = ST_REQ;
                    valid_d    = 1'b0;
                    insn_d     = NOP_INSN;
                    misalign_d = 1'b0;
                    if (redirect) begin
                        pc_d = target;
                    end else if (!flush_f && !misalign_q) begin
                        pc_d = pc_q + XLEN'(4);
                    end
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // State and output registers; reset kills any in-flight request by arming drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            drop_q       <= req_live;
            pend_pc_q    <= req_live ? RESET_PC : '0;
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_insn     <= NOP_INSN;
            misalign_q   <= 1'b0;
            reset_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            pend_pc_q    <= pend_pc_d;
            out_valid    <= valid_d;
            out_pc       <= out_pc_d;
            out_insn     <= insn_d;
            misalign_q   <= misalign_d;
            reset_q      <= 1'b0;
        end
    end

endmodule
